wb_arbiter: RTL and testbench



---
 rtl/wb_arbiter_pkg.sv | 21 ++
 rtl/wb_fifo.sv | 67 ++++++
 rtl/wb_arbiter.sv | 170 +++++++++++++++++
 tb/tb_wb_arbiter.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_arbiter_pkg.sv
// rtl/wb_arbiter_pkg.sv - shared constants and types for the writeback arbiter
// Holds the ROB tag width, source index constants, the writeback record
// type and the round-robin advance helper used by wb_arbiter.
package wb_arbiter_pkg;

  localparam int ROB_WIDTH = 4;

  localparam int SRC_ALU = 0;
  localparam int SRC_LSB = 1;

  typedef struct packed {
    logic [ROB_WIDTH-1:0] rob_id;
    logic [31:0]          value;
  } wb_rec_t;

  // Index of the source after cur, wrapping back to 0 past the last source.
  function automatic int rr_advance(input int cur, input int n);
    return (cur + 1 >= n) ? 0 : cur + 1;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - per-source writeback result FIFO
// Small DEPTH-entry FIFO holding {rob_id, value} results of one source.
// Ports:
//   clk_in, rst_n_in  clock, asynchronous active-low reset
//   flush             empties the FIFO; wins over push and pop
//   push, push_data   write one entry (ignored while full)
//   pop               drop the head entry (ignored while empty)
//   head              current head entry (valid while !empty)
//   full, empty       derived from the registered count
//   count             number of stored entries, clog2(DEPTH)+1 bits
module wb_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 36
) (
  input  logic                   clk_in,
  input  logic                   rst_n_in,
  input  logic                   flush,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic [WIDTH-1:0]       head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rd_ptr;
  logic [PW-1:0]    wr_ptr;
  logic             push_en;
  logic             pop_en;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign push_en = push && !full && !flush;
  assign pop_en  = pop && !empty && !flush;
  assign head    = mem[rd_ptr];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + PW'(1);
      if (pop_en)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_en, pop_en})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (push_en) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/wb_arbiter.sv
// rtl/wb_arbiter.sv - round-robin writeback (CDB) arbiter feeding the ROB
// Each source pushes (rob_id, value) into its own wb_fifo; one result per
// cycle is granted round-robin onto a registered broadcast bus.
// Optional feature macro: WB_BYPASS_EN (an accepted input whose FIFO is empty
// may win arbitration and go straight to the output registers).
// Ports:
//   clk_in, rst_n_in  clock, asynchronous active-low reset
//   rdy_in            global enable; low freezes all state
//   clear_in          mispredict flush, one cycle, highest priority
//   src_valid         per-source result valid
//   src_rob_id        per-source ROB tag, source i in slice i
//   src_value         per-source 32-bit result, source i in slice i
//   src_full          per-source FIFO full; source holds its result while high
//   cdb_valid         broadcast valid, one-cycle pulse per result
//   cdb_rob_id        broadcast tag
//   cdb_value         broadcast value
//   cdb_src           index of the source that produced the broadcast
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int N_SRC = 2,
  parameter int DEPTH = 2,
  parameter int ROB_W = ROB_WIDTH
) (
  input  logic                     clk_in,
  input  logic                     rst_n_in,
  input  logic                     rdy_in,
  input  logic                     clear_in,
  input  logic [N_SRC-1:0]         src_valid,
  input  logic [N_SRC*ROB_W-1:0]   src_rob_id,
  input  logic [N_SRC*32-1:0]      src_value,
  output logic [N_SRC-1:0]         src_full,
  output logic                     cdb_valid,
  output logic [ROB_W-1:0]         cdb_rob_id,
  output logic [31:0]              cdb_value,
  output logic [$clog2(N_SRC)-1:0] cdb_src
);

  localparam int SW = $clog2(N_SRC);
  localparam int DW = ROB_W + 32;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [DW-1:0]    in_data    [N_SRC];
  logic [DW-1:0]    fifo_head  [N_SRC];
  logic [CW-1:0]    fifo_count [N_SRC];
  logic [N_SRC-1:0] fifo_empty;
  logic [N_SRC-1:0] fifo_full;
  logic [N_SRC-1:0] accept;
  logic [N_SRC-1:0] cand;
  logic [N_SRC-1:0] push;
  logic [N_SRC-1:0] pop;
  logic [SW-1:0]    rr_ptr;
  logic [SW-1:0]    win;
  logic             found;
  logic [DW-1:0]    win_data;
  logic             flush;

  assign flush    = rdy_in && clear_in;
  assign src_full = fifo_full;

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    assign in_data[g] = {src_rob_id[g*ROB_W +: ROB_W], src_value[g*32 +: 32]};
    // src_full comes from the registered count, so a same-cycle pop does
    // not open a slot for the source until the following cycle.
    assign accept[g]  = rdy_in && !clear_in && src_valid[g] && !fifo_full[g];

    wb_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (DW)
    ) u_fifo (
      .clk_in    (clk_in),
      .rst_n_in  (rst_n_in),
      .flush     (flush),
      .push      (push[g]),
      .push_data (in_data[g]),
      .pop       (pop[g]),
      .head      (fifo_head[g]),
      .full      (fifo_full[g]),
      .empty     (fifo_empty[g]),
      .count     (fifo_count[g])
    );

    a_count_range: assert property (@(posedge clk_in) disable iff (!rst_n_in)
      fifo_count[g] <= CW'(DEPTH));

    // A source refused because its FIFO is full must keep presenting the
    // same result; withdrawing or changing it loses that result.
    a_hold_when_full: assert property (@(posedge clk_in) disable iff (!rst_n_in)
      (rdy_in && !clear_in && src_valid[g] && fifo_full[g]) |=>
        (clear_in || (src_valid[g] &&
                      $stable(src_rob_id[g*ROB_W +: ROB_W]) &&
                      $stable(src_value[g*32 +: 32]))));
  end

  always_comb begin
    cand = '0;
    for (int i = 0; i < N_SRC; i++) begin
`ifdef WB_BYPASS_EN
      cand[i] = !fifo_empty[i] || accept[i];
`else
      cand[i] = !fifo_empty[i];
`endif
    end
  end

  // Round-robin scan: first the sources at or above rr_ptr, then the ones
  // below it, which is the same as scanning upward modulo N_SRC.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (!found && cand[i] && (SW'(i) >= rr_ptr)) begin
        found = 1'b1;
        win   = SW'(i);
      end
    end
    for (int i = 0; i < N_SRC; i++) begin
      if (!found && cand[i] && (SW'(i) < rr_ptr)) begin
        found = 1'b1;
        win   = SW'(i);
      end
    end
  end

  always_comb begin
    push     = '0;
    pop      = '0;
    win_data = '0;
    for (int i = 0; i < N_SRC; i++) begin
      push[i] = accept[i];
      if (found && (win == SW'(i))) begin
        if (!fifo_empty[i]) begin
          pop[i]   = rdy_in && !clear_in;
          win_data = fifo_head[i];
        end
`ifdef WB_BYPASS_EN
        else begin
          // Winner had nothing queued: its input skips the FIFO entirely.
          push[i]  = 1'b0;
          win_data = in_data[i];
        end
`endif
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      rr_ptr     <= '0;
      cdb_valid  <= 1'b0;
      cdb_rob_id <= '0;
      cdb_value  <= '0;
      cdb_src    <= '0;
    end else if (rdy_in) begin
      if (clear_in) begin
        rr_ptr    <= '0;
        cdb_valid <= 1'b0;
      end else begin
        cdb_valid <= found;
        if (found) begin
          rr_ptr     <= SW'(rr_advance(int'(win), N_SRC));
          cdb_rob_id <= win_data[DW-1 -: ROB_W];
          cdb_value  <= win_data[31:0];
          cdb_src    <= win;
        end
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// tb/tb_wb_arbiter.sv - scoreboard testbench for wb_arbiter
module tb_wb_arbiter;
  import wb_arbiter_pkg::*;

`ifdef WB_BYPASS_EN
  localparam int LAT = 1;
`else
  localparam int LAT = 2;
`endif

  logic        clk_in = 1'b0;
  logic        rst_n_in;
  logic        rdy_in;
  logic        clear_in;
  logic [1:0]  src_valid;
  logic [7:0]  src_rob_id;
  logic [63:0] src_value;
  logic [1:0]  src_full;
  logic        cdb_valid;
  logic [3:0]  cdb_rob_id;
  logic [31:0] cdb_value;
  logic [0:0]  cdb_src;

  int      checks = 0;
  int      errors = 0;
  wb_rec_t exp0[$];
  wb_rec_t exp1[$];
  int      src_log[$];
  logic    load_edge;
  logic    saw_full1;
  int      stalls1;
  logic [1:0] acc;

  wb_arbiter dut (
    .clk_in     (clk_in),
    .rst_n_in   (rst_n_in),
    .rdy_in     (rdy_in),
    .clear_in   (clear_in),
    .src_valid  (src_valid),
    .src_rob_id (src_rob_id),
    .src_value  (src_value),
    .src_full   (src_full),
    .cdb_valid  (cdb_valid),
    .cdb_rob_id (cdb_rob_id),
    .cdb_value  (cdb_value),
    .cdb_src    (cdb_src)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish (checks=%0d errors=%0d)", checks, errors);
    $fatal(1);
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // A new broadcast is present only if the last edge was an enabled one.
  always @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) load_edge <= 1'b0;
    else           load_edge <= rdy_in;
  end

  always @(negedge clk_in) begin
    wb_rec_t got;
    wb_rec_t want;
    if (rst_n_in && load_edge && cdb_valid) begin
      got.rob_id = cdb_rob_id;
      got.value  = cdb_value;
      src_log.push_back(int'(cdb_src));
      if (int'(cdb_src) == SRC_ALU) begin
        if (exp0.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_src0_unexpected: got tag %0d value 0x%0h, expected nothing", cdb_rob_id, cdb_value);
        end else begin
          want = exp0.pop_front();
          chk("sb_src0", 64'(got), 64'(want));
        end
      end else begin
        if (exp1.size() == 0) begin
          checks++; errors++;
          $display("FAIL sb_src1_unexpected: got tag %0d value 0x%0h, expected nothing", cdb_rob_id, cdb_value);
        end else begin
          want = exp1.pop_front();
          chk("sb_src1", 64'(got), 64'(want));
        end
      end
    end
  end

  // One cycle of stimulus: drive at the negedge, predict acceptance from the
  // registered src_full, and return right after the following posedge.
  task automatic step(input logic [1:0] v, input logic [3:0] id0, input logic [31:0] d0,
                      input logic [3:0] id1, input logic [31:0] d1, input logic clr,
                      output logic [1:0] a);
    wb_rec_t r;
    @(negedge clk_in);
    src_valid  = v;
    src_rob_id = {id1, id0};
    src_value  = {d1, d0};
    clear_in   = clr;
    for (int i = 0; i < 2; i++) a[i] = rdy_in && v[i] && !src_full[i] && !clr;
    if (a[0]) begin r.rob_id = id0; r.value = d0; exp0.push_back(r); end
    if (a[1]) begin r.rob_id = id1; r.value = d1; exp1.push_back(r); end
    @(posedge clk_in);
    if (clr && rdy_in) begin
      exp0.delete();
      exp1.delete();
    end
  endtask

  task automatic idle();
    logic [1:0] a;
    step(2'b00, 4'd0, 32'd0, 4'd0, 32'd0, 1'b0, a);
  endtask

  // Each source offers its current item until accepted, then the next one.
  task automatic run_streams(input int n0, input logic [3:0] t0, input int n1, input logic [3:0] t1);
    int i0 = 0;
    int i1 = 0;
    logic [1:0] v;
    logic [1:0] a;
    for (int guard = 0; guard < 200 && (i0 < n0 || i1 < n1); guard++) begin
      v = {i1 < n1, i0 < n0};
      step(v, t0 + 4'(i0), 32'h5A00_0000 + 32'(t0 + 4'(i0)),
              t1 + 4'(i1), 32'hA500_0000 + 32'(t1 + 4'(i1)), 1'b0, a);
      if (v[1] && !a[1]) stalls1++;
      if (a[0]) i0++;
      if (a[1]) i1++;
      #1;
      if (src_full[1]) saw_full1 = 1'b1;
    end
    chk("stream_all_accepted", 64'(i0 + i1), 64'(n0 + n1));
  endtask

  task automatic drain(input string name);
    int k = 0;
    while ((exp0.size() + exp1.size()) != 0 && k < 30) begin
      idle();
      k++;
    end
    chk({name, "_drained"}, 64'(exp0.size() + exp1.size()), 64'd0);
    repeat (3) idle();
  endtask

  initial begin
    rst_n_in   = 1'b0;
    rdy_in     = 1'b1;
    clear_in   = 1'b0;
    src_valid  = '0;
    src_rob_id = '0;
    src_value  = '0;
    saw_full1  = 1'b0;
    stalls1    = 0;

    // Reset state
    repeat (2) @(negedge clk_in);
    chk("rst_cdb_valid", 64'(cdb_valid), 64'd0);
    chk("rst_cdb_rob_id", 64'(cdb_rob_id), 64'd0);
    chk("rst_cdb_value", 64'(cdb_value), 64'd0);
    chk("rst_cdb_src", 64'(cdb_src), 64'd0);
    chk("rst_src_full", 64'(src_full), 64'd0);
    rst_n_in = 1'b1;

    // 1: single result, latency LAT
    step(2'b01, 4'd3, 32'h0000_00AA, 4'd0, 32'd0, 1'b0, acc);
    chk("t1_accept", 64'(acc), 64'd1);
    repeat (LAT - 1) idle();
    #1;
    chk("t1_valid", 64'(cdb_valid), 64'd1);
    chk("t1_rob_id", 64'(cdb_rob_id), 64'd3);
    chk("t1_value", 64'(cdb_value), 64'h0000_00AA);
    chk("t1_src", 64'(cdb_src), 64'd0);
    idle();
    #1;
    chk("t1_pulse_end", 64'(cdb_valid), 64'd0);
    drain("t1");

    // rr_ptr is now 1; a clear must put it back to 0 for the next test
    step(2'b00, 4'd0, 32'd0, 4'd0, 32'd0, 1'b1, acc);

    // 2: contention, grants alternate starting with source 0
    src_log.delete();
    run_streams(6, 4'd1, 6, 4'd9);
    drain("t2");
    chk("t2_count", 64'(src_log.size()), 64'd12);
    for (int k = 0; k < src_log.size(); k++)
      chk($sformatf("t2_order%0d", k), 64'(src_log[k]), 64'(k % 2));

    // 3: backpressure on source 1 while source 0 keeps it busy
    saw_full1 = 1'b0;
    stalls1   = 0;
    run_streams(6, 4'd0, 4, 4'd12);
    drain("t3");
    chk("t3_saw_full1", 64'(saw_full1), 64'd1);
    chk("t3_stalled", 64'(stalls1 > 0), 64'd1);

    // 4: flush with pending results and a same-cycle input (tag 7)
    repeat (3) step(2'b11, 4'd1, 32'h0000_0011, 4'd2, 32'h0000_0022, 1'b0, acc);
    step(2'b01, 4'd7, 32'h0000_0077, 4'd0, 32'd0, 1'b1, acc);
    #1;
    chk("t4_valid", 64'(cdb_valid), 64'd0);
    chk("t4_full", 64'(src_full), 64'd0);
    src_log.delete();
    repeat (3) idle();
    chk("t4_no_output", 64'(src_log.size()), 64'd0);
    run_streams(1, 4'd8, 1, 4'd9);
    drain("t4");
    chk("t4_rr_first", 64'(src_log.size() > 0 ? src_log[0] : 9), 64'd0);

    // 5: freeze with one result still queued
    step(2'b11, 4'd5, 32'h0000_0055, 4'd6, 32'h0000_0066, 1'b0, acc);
    chk("t5_accept", 64'(acc), 64'd3);
    repeat (LAT - 1) idle();
    #1;
    chk("t5_first_rob", 64'(cdb_rob_id), 64'd5);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_in);
      rdy_in    = 1'b0;
      src_valid = '0;
      @(posedge clk_in);
      #1;
      chk($sformatf("t5_frz_valid%0d", c), 64'(cdb_valid), 64'd1);
      chk($sformatf("t5_frz_rob%0d", c), 64'(cdb_rob_id), 64'd5);
      chk($sformatf("t5_frz_src%0d", c), 64'(cdb_src), 64'd0);
      chk($sformatf("t5_frz_full%0d", c), 64'(src_full), 64'd0);
    end
    @(negedge clk_in);
    rdy_in = 1'b1;
    @(posedge clk_in);
    #1;
    chk("t5_resume_valid", 64'(cdb_valid), 64'd1);
    chk("t5_resume_rob", 64'(cdb_rob_id), 64'd6);
    chk("t5_resume_src", 64'(cdb_src), 64'd1);
    drain("t5");

    // 6: asynchronous reset in the middle of a cycle with results pending
    step(2'b11, 4'd3, 32'h0000_0033, 4'd4, 32'h0000_0044, 1'b0, acc);
    step(2'b11, 4'd3, 32'h0000_0033, 4'd4, 32'h0000_0044, 1'b0, acc);
    #1;
    chk("t6_pre_valid", 64'(cdb_valid), 64'd1);
    #1;
    rst_n_in  = 1'b0;
    src_valid = '0;
    #1;
    chk("t6_async_valid", 64'(cdb_valid), 64'd0);
    chk("t6_async_rob", 64'(cdb_rob_id), 64'd0);
    chk("t6_async_full", 64'(src_full), 64'd0);
    exp0.delete();
    exp1.delete();
    @(negedge clk_in);
    rst_n_in = 1'b1;
    src_log.delete();
    repeat (4) idle();
    chk("t6_no_output", 64'(src_log.size()), 64'd0);
    chk("t6_full_after", 64'(src_full), 64'd0);
    run_streams(1, 4'd10, 0, 4'd0);
    drain("t6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
